// File: rtl/gugu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package gugu_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with next-pc selection: reset, redirect, sequential increment.
module if_pc_reg
    import gugu_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned            PC_INC   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   inc_en_i,
    output logic [INST_ADDR_W-1:0] pc_o
);

    localparam logic [INST_ADDR_W-1:0] PC_STEP = INST_ADDR_W'(PC_INC);

    logic [INST_ADDR_W-1:0] pc_q;
    logic [INST_ADDR_W-1:0] pc_d;

    // Redirect wins over the increment; the add wraps naturally at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (branch_flag_i) begin
            pc_d = branch_target_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// IF stage: fetch FSM over a req/addr_ok/data_ok handshake with stall and redirect squash.
// Define IF_ADDR_ERR_EN to add the if_adel port and misaligned-fetch exception reporting.
module inst_fetch
    import gugu_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned            PC_INC   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    output logic                   inst_req,
    output logic [INST_ADDR_W-1:0] inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [INST_W-1:0]      inst_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
`ifdef IF_ADDR_ERR_EN
    output logic                   if_valid,
    output logic                   if_adel
`else
    output logic                   if_valid
`endif
);

    fetch_state_t           state_q, state_d;
    logic                   discard_q, discard_d;
    logic [INST_ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [INST_ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0]      if_inst_q, if_inst_d;
    logic                   if_valid_q, if_valid_d;
    logic                   adel_q, adel_d;
    logic [INST_ADDR_W-1:0] pc;
    logic                   misalign;

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .clk_i           (clk),
        .rst_n_i         (rst),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .inc_en_i        (inst_req & inst_addr_ok),
        .pc_o            (pc)
    );

`ifdef IF_ADDR_ERR_EN
    assign misalign  = |pc[1:0];
    assign inst_addr = pc;
    assign if_adel   = adel_q;
`else
    // Misalignment is not reported; the low bits are simply masked off the bus.
    assign misalign  = 1'b0;
    assign inst_addr = pc & ~INST_ADDR_W'(3);
`endif

    assign inst_req = (state_q == S_REQ) && !misalign;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        adel_d     = adel_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if_valid_d = 1'b0;
                if (misalign && !branch_flag) begin
                    if_pc_d    = pc;
                    if_inst_d  = ZERO_WORD;
                    if_valid_d = 1'b1;
                    adel_d     = 1'b1;
                    state_d    = S_HOLD;
                end else if (inst_req && inst_addr_ok) begin
                    // A redirect in the accept cycle marks this fetch for squashing.
                    req_pc_d  = pc;
                    discard_d = branch_flag;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    discard_d = 1'b0;
                    state_d   = S_REQ;
                    if (discard_q || branch_flag) begin
                        if_valid_d = 1'b0;
                    end else begin
                        if_pc_d    = req_pc_q;
                        if_inst_d  = inst_rdata;
                        if_valid_d = 1'b1;
                        if (stall) begin
                            state_d = S_HOLD;
                        end
                    end
                end else if (branch_flag) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                // An address-error entry is released only by the exception redirect.
                if (adel_q) begin
                    if (branch_flag) begin
                        if_valid_d = 1'b0;
                        adel_d     = 1'b0;
                        state_d    = S_REQ;
                    end
                end else if (!stall || branch_flag) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= ZERO_WORD;
            if_valid_q <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            adel_q     <= adel_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

endmodule
